// File: rtl/gain_divider_iter.sv
// gain_divider_iter: recovers a DATA_WIDTH-bit sample from a 2*DATA_WIDTH-bit gained
// product by dividing it by the gain. Iterative restoring divider on operand magnitudes,
// one quotient bit per clock, valid/ready handshakes on both sides.
// Optional build macro: GAIN_DIV_SATURATE_EN -- clamp o_data on overflow and divide-by-zero
// instead of wrapping / returning all-ones.
`timescale 1ns/1ps
module gain_divider_iter #(
    parameter int DATA_WIDTH = 16,
    parameter int IS_SIGNED  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [2*DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH-1:0]     i_gain,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [DATA_WIDTH-1:0]     o_rem,
    output logic                      o_ovf,
    output logic                      o_div0
);

    localparam int W  = DATA_WIDTH;
    localparam int DW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [W-1:0]  ALL_ONES = '1;
    localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quo_r;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [W-1:0]  rem_r;      // partial remainder magnitude
    logic [W-1:0]  div_r;      // divisor magnitude
    logic [W-1:0]  raw_lo_r;   // low half of the raw dividend, returned as remainder on divide-by-zero
    logic          sign_d_r;
    logic          sign_g_r;
    logic          div0_r;

    logic          in_sign_d;
    logic          in_sign_g;
    logic [DW-1:0] in_mag_d;
    logic [W-1:0]  in_mag_g;

    logic [W:0]    rem_shift;
    logic [W:0]    rem_sub;
    logic          q_bit;

    logic [W-1:0]  q_lo;
    logic          hi_zero;
    logic          neg_q;
    logic [W-1:0]  q_signed;
    logic [W-1:0]  rem_signed;
    logic [W-1:0]  fix_data;
    logic [W-1:0]  fix_rem;
    logic          fix_ovf;

    // Operand signs and magnitudes at the input port (magnitude of the most negative value
    // is still exact because it is interpreted as unsigned).
    always_comb begin
        in_sign_d = (IS_SIGNED != 0) ? i_data[DW-1] : 1'b0;
        in_sign_g = (IS_SIGNED != 0) ? i_gain[W-1]  : 1'b0;
        in_mag_d  = in_sign_d ? -i_data : i_data;
        in_mag_g  = in_sign_g ? -i_gain : i_gain;
    end

    // One restoring shift-subtract step.
    always_comb begin
        rem_shift = {rem_r, quo_r[DW-1]};
        rem_sub   = rem_shift - {1'b0, div_r};
        q_bit     = (rem_shift >= {1'b0, div_r});
    end

    // Final correction: signs, overflow range check, divide-by-zero and optional clamping.
    always_comb begin
        q_lo       = quo_r[W-1:0];
        hi_zero    = (quo_r[DW-1:W] == '0);
        neg_q      = sign_d_r ^ sign_g_r;
        q_signed   = neg_q ? -q_lo : q_lo;
        rem_signed = sign_d_r ? -rem_r : rem_r;

        if (IS_SIGNED != 0) begin
            if (neg_q) begin
                fix_ovf = !hi_zero || (q_lo > MIN_NEG);
            end else begin
                fix_ovf = !hi_zero || q_lo[W-1];
            end
        end else begin
            fix_ovf = !hi_zero;
        end

        fix_data = q_signed;
        fix_rem  = rem_signed;
`ifdef GAIN_DIV_SATURATE_EN
        if (fix_ovf) begin
            fix_data = (IS_SIGNED != 0) ? (neg_q ? MIN_NEG : MAX_POS) : ALL_ONES;
        end
`endif

        if (div0_r) begin
            fix_ovf = 1'b0;
            fix_rem = raw_lo_r;
`ifdef GAIN_DIV_SATURATE_EN
            fix_data = (IS_SIGNED != 0) ? (sign_d_r ? MIN_NEG : MAX_POS) : ALL_ONES;
`else
            fix_data = ALL_ONES;
`endif
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            div_r    <= '0;
            raw_lo_r <= '0;
            sign_d_r <= 1'b0;
            sign_g_r <= 1'b0;
            div0_r   <= 1'b0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_rem    <= '0;
            o_ovf    <= 1'b0;
            o_div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        quo_r    <= in_mag_d;
                        rem_r    <= '0;
                        div_r    <= in_mag_g;
                        raw_lo_r <= i_data[W-1:0];
                        sign_d_r <= in_sign_d;
                        sign_g_r <= in_sign_g;
                        div0_r   <= (i_gain == '0);
                        cnt      <= '0;
                        o_ready  <= 1'b0;
                        o_ovf    <= 1'b0;
                        o_div0   <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Divide-by-zero runs the full iteration count too, keeping latency constant.
                    quo_r <= {quo_r[DW-2:0], q_bit};
                    rem_r <= q_bit ? rem_sub[W-1:0] : rem_shift[W-1:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    o_data  <= fix_data;
                    o_rem   <= fix_rem;
                    o_ovf   <= fix_ovf;
                    o_div0  <= div0_r;
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gain_divider_iter.sv
// Testbench for gain_divider_iter: a signed and an unsigned instance run in lockstep on the
// same stimulus; an arithmetic reference model plus hand-computed vectors check both.
`timescale 1ns/1ps
module tb_gain_divider_iter;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_data;
    logic [15:0] i_gain;

    logic        s_ready, s_valid, s_ovf, s_div0;
    logic [15:0] s_data, s_rem;
    logic        u_ready, u_valid, u_ovf, u_div0;
    logic [15:0] u_data, u_rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gain_divider_iter #(.DATA_WIDTH(W), .IS_SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_data(i_data), .i_gain(i_gain), .o_valid(s_valid), .i_ready(i_ready),
        .o_data(s_data), .o_rem(s_rem), .o_ovf(s_ovf), .o_div0(s_div0)
    );

    gain_divider_iter #(.DATA_WIDTH(W), .IS_SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(u_ready),
        .i_data(i_data), .i_gain(i_gain), .o_valid(u_valid), .i_ready(i_ready),
        .o_data(u_data), .o_rem(u_rem), .o_ovf(u_ovf), .o_div0(u_div0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] rem;
        logic        ovf;
        logic        div0;
    } res_t;

    // Reference division in 64-bit integer arithmetic.
    function automatic res_t model(input bit sgn, input logic [31:0] d, input logic [15:0] g);
        longint a, b, q, r;
        res_t   res;
        if (sgn) begin
            a = longint'($signed(d));
            b = longint'($signed(g));
        end else begin
            a = longint'({32'b0, d});
            b = longint'({48'b0, g});
        end
        if (b == 0) begin
            res.div0 = 1'b1;
            res.ovf  = 1'b0;
            res.rem  = d[15:0];
`ifdef GAIN_DIV_SATURATE_EN
            res.data = sgn ? ((a < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`else
            res.data = 16'hFFFF;
`endif
        end else begin
            q = a / b;
            r = a % b;
            res.div0 = 1'b0;
            res.ovf  = sgn ? (q < -32768 || q > 32767) : (q > 65535);
            res.rem  = r[15:0];
            res.data = q[15:0];
`ifdef GAIN_DIV_SATURATE_EN
            if (res.ovf) res.data = sgn ? ((q < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
        end
        return res;
    endfunction

    // Protocol timeline: 0 idle, 1 computing, 2 result held.
    int   m_phase = 0;
    int   m_cnt   = 0;
    res_t exp_s, exp_u;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else if (m_phase == 0) begin
            if (i_valid) begin
                m_phase <= 1;
                m_cnt   <= 0;
                exp_s   <= model(1'b1, i_data, i_gain);
                exp_u   <= model(1'b0, i_data, i_gain);
            end
        end else if (m_phase == 1) begin
            if (m_cnt == 2 * W) m_phase <= 2;
            else m_cnt <= m_cnt + 1;
        end else if (i_ready) begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", s_ready, m_phase == 0);
            chk("u_ready", u_ready, m_phase == 0);
            chk("s_valid", s_valid, m_phase == 2);
            chk("u_valid", u_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("s_data", s_data, exp_s.data);
                chk("s_rem",  s_rem,  exp_s.rem);
                chk("s_ovf",  s_ovf,  exp_s.ovf);
                chk("s_div0", s_div0, exp_s.div0);
                chk("u_data", u_data, exp_u.data);
                chk("u_rem",  u_rem,  exp_u.rem);
                chk("u_ovf",  u_ovf,  exp_u.ovf);
                chk("u_div0", u_div0, exp_u.div0);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_s_valid"}, s_valid, 1'b0);
        chk({tag, "_s_data"},  s_data,  16'h0000);
        chk({tag, "_s_rem"},   s_rem,   16'h0000);
        chk({tag, "_s_flags"}, {s_ovf, s_div0}, 2'b00);
        chk({tag, "_u_ready"}, u_ready, 1'b1);
        chk({tag, "_u_valid"}, u_valid, 1'b0);
        chk({tag, "_u_data"},  u_data,  16'h0000);
        chk({tag, "_u_rem"},   u_rem,   16'h0000);
        chk({tag, "_u_flags"}, {u_ovf, u_div0}, 2'b00);
    endtask

    // One directed operation with hand-computed results for both instances
    // (sw/uw: wrapping build, ss/us: saturating build).
    task automatic run_op(input logic [31:0] d, input logic [15:0] g,
                          input logic [15:0] sw, input logic [15:0] ss, input logic [15:0] sr,
                          input logic so, input logic sz,
                          input logic [15:0] uw, input logic [15:0] us, input logic [15:0] ur,
                          input logic uo, input logic uz, input int hold);
        int          lat;
        logic [15:0] sx, ux;
`ifdef GAIN_DIV_SATURATE_EN
        sx = ss;
        ux = us;
`else
        sx = sw;
        ux = uw;
`endif
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        i_gain  = g;
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = ~d;
        i_gain  = ~g;
        lat = 0;
        while (!s_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 33);
        chk("lit_s_data", s_data, sx);
        chk("lit_s_rem",  s_rem,  sr);
        chk("lit_s_ovf",  s_ovf,  so);
        chk("lit_s_div0", s_div0, sz);
        chk("lit_u_valid", u_valid, 1'b1);
        chk("lit_u_data", u_data, ux);
        chk("lit_u_rem",  u_rem,  ur);
        chk("lit_u_ovf",  u_ovf,  uo);
        chk("lit_u_div0", u_div0, uz);
        repeat (hold) begin
            @(negedge clk);
            i_valid = ~i_valid;
            i_data  = $urandom;
            i_gain  = 16'($urandom);
            chk("hold_s_valid", s_valid, 1'b1);
            chk("hold_s_ready", s_ready, 1'b0);
            chk("hold_s_data",  s_data,  sx);
            chk("hold_s_flags", {s_ovf, s_div0}, {so, sz});
            chk("hold_u_data",  u_data,  ux);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("back_s_ready", s_ready, 1'b1);
        chk("back_u_ready", u_ready, 1'b1);
        chk("back_s_valid", s_valid, 1'b0);
    endtask

    initial begin
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_gain  = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        run_op(32'h00001B58, 16'h0007, 16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0,
               16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0, 5);
        run_op(32'hFFFFE2B4, 16'h0019, 16'hFED4, 16'hFED4, 16'h0000, 1'b0, 1'b0,
               16'h6F77, 16'hFFFF, 16'h0015, 1'b1, 1'b0, 0);
        run_op(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0,
               16'hFFFC, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
        run_op(32'h00010000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0,
               16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(32'h80000000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0,
               16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        run_op(32'hFFFF8000, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0,
               16'h8000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(32'h00000064, 16'hFFF9, 16'hFFF2, 16'hFFF2, 16'h0002, 1'b0, 1'b0,
               16'h0000, 16'h0000, 16'h0064, 1'b0, 1'b0, 0);
        run_op(32'hFFFFFF9C, 16'hFFF9, 16'h000E, 16'h000E, 16'hFFFE, 1'b0, 1'b0,
               16'h0006, 16'hFFFF, 16'hFFC6, 1'b1, 1'b0, 0);
        run_op(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0,
               16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
        run_op(32'hFFFFFF00, 16'h0000, 16'hFFFF, 16'h8000, 16'hFF00, 1'b0, 1'b1,
               16'hFFFF, 16'hFFFF, 16'hFF00, 1'b0, 1'b1, 0);
        run_op(32'h000004D2, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h04D2, 1'b0, 1'b1,
               16'hFFFF, 16'hFFFF, 16'h04D2, 1'b0, 1'b1, 2);

        // Abort mid-computation: outputs must fall to reset values without waiting for a clock.
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 32'd7000;
        i_gain  = 16'd7;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;

        run_op(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0,
               16'hFFFC, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
        run_op(32'h00001B58, 16'h0007, 16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0,
               16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
